// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS instruction field positions, opcode constants
//                and fetch state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int SH_MSB   = 10;
    localparam int SH_LSB   = 6;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    localparam logic [5:0]  OPC_RTYPE        = 6'h00;
    localparam logic [5:0]  FUNC_SYSCALL     = 6'h0C;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic is_syscall(input logic [5:0] opcode, input logic [5:0] func);
        return (opcode == OPC_RTYPE) && (func == FUNC_SYSCALL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
//  Module      : instruction_fetch_if
//  Description : Instruction-memory read port plus datapath-side decoded
//                instruction bundle of the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [5:0]        opcode;
    logic [4:0]        rs_num;
    logic [4:0]        rt_num;
    logic [4:0]        rd_num;
    logic [4:0]        sh_mount;
    logic [5:0]        func;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] pc_value;
    logic              halted;

    modport master (
        output imem_req, imem_addr, inst_valid, opcode, rs_num, rt_num, rd_num,
               sh_mount, func, imm, pc_value, halted,
        input  imem_ack, imem_rdata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, opcode, rs_num, rt_num, rd_num,
               sh_mount, func, imm, pc_value, halted,
        output imem_ack, imem_rdata, stall, redirect_valid, redirect_pc
    );

endinterface

`default_nettype wire

// File: rtl/instr_splitter.sv
// ============================================================================
//  Module      : instr_splitter
//  Description : Combinational split of a 32-bit MIPS word into its fields.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_splitter
    import mips_pkg::*;
(
    input  wire logic [31:0] i_inst,
    output logic      [5:0]  o_opcode,
    output logic      [4:0]  o_rs,
    output logic      [4:0]  o_rt,
    output logic      [4:0]  o_rd,
    output logic      [4:0]  o_sh,
    output logic      [5:0]  o_func,
    output logic      [15:0] o_imm
);

    assign o_opcode = i_inst[OPC_MSB:OPC_LSB];
    assign o_rs     = i_inst[RS_MSB:RS_LSB];
    assign o_rt     = i_inst[RT_MSB:RT_LSB];
    assign o_rd     = i_inst[RD_MSB:RD_LSB];
    assign o_sh     = i_inst[SH_MSB:SH_LSB];
    assign o_func   = i_inst[FUNC_MSB:FUNC_LSB];
    assign o_imm    = i_inst[IMM_MSB:IMM_LSB];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module      : instruction_fetch
//  Description : MIPS fetch front end: reads imem, holds the split word for the
//                datapath, follows redirects and stops after a syscall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    instruction_fetch_if.master bus
);

    localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);

    fetch_state_t      r_state, w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next;
    logic [ADDR_W-1:0] r_pc_value, w_pc_value_next;
    logic [31:0]       r_inst, w_inst_next;
    logic              r_req, w_req_next;
    logic              r_valid, w_valid_next;
    logic              r_halted, w_halted_next;

    logic [5:0]        w_opcode, w_func;
    logic [4:0]        w_rs, w_rt, w_rd, w_sh;
    logic [15:0]       w_imm;

    instr_splitter u_splitter (
        .i_inst   (r_inst),
        .o_opcode (w_opcode),
        .o_rs     (w_rs),
        .o_rt     (w_rt),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_func   (w_func),
        .o_imm    (w_imm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_START;
            r_fetch_pc <= RESET_PC;
            r_pc_value <= '0;
            r_inst     <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_pc_value <= w_pc_value_next;
            r_inst     <= w_inst_next;
            r_req      <= w_req_next;
            r_valid    <= w_valid_next;
            r_halted   <= w_halted_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_pc_value_next = r_pc_value;
        w_inst_next     = r_inst;
        w_req_next      = r_req;
        w_valid_next    = r_valid;
        w_halted_next   = r_halted;
        case (r_state)
            ST_START: begin
                w_state_next = ST_FETCH;
                w_req_next   = 1'b1;
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    w_inst_next     = bus.imem_rdata;
                    w_pc_value_next = r_fetch_pc;
                    w_req_next      = 1'b0;
                    w_valid_next    = 1'b1;
                    w_state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.stall) begin
                    w_valid_next = 1'b0;
                    // A consumed syscall ends fetching; any redirect on that edge is dropped
                    if (is_syscall(w_opcode, w_func)) begin
                        w_halted_next = 1'b1;
                        w_state_next  = ST_HALT;
                    end else begin
                        w_fetch_pc_next = bus.redirect_valid ? (bus.redirect_pc & c_align_mask)
                                                             : (r_fetch_pc + c_pc_step);
                        w_req_next      = 1'b1;
                        w_state_next    = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_START;
            end
        endcase
    end

    assign bus.imem_req   = r_req;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = r_valid;
    assign bus.opcode     = w_opcode;
    assign bus.rs_num     = w_rs;
    assign bus.rt_num     = w_rt;
    assign bus.rd_num     = w_rd;
    assign bus.sh_mount   = w_sh;
    assign bus.func       = w_func;
    assign bus.imm        = w_imm;
    assign bus.pc_value   = r_pc_value;
    assign bus.halted     = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Directed self-checking bench for instruction_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  func;
        logic [15:0] imm;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    instruction_fetch_if #(.ADDR_W(32)) bus ();

    instruction_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0040_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", {31'b0, bus.imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr);
        wait_req();
        check("imem_addr", bus.imem_addr, exp_addr);
        bus.imem_rdata = word;
        bus.imem_ack   = 1'b1;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic check_fields(input vec_t v, input logic [31:0] pc);
        check("inst_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("opcode",     {26'b0, bus.opcode},   {26'b0, v.opcode});
        check("rs_num",     {27'b0, bus.rs_num},   {27'b0, v.rs});
        check("rt_num",     {27'b0, bus.rt_num},   {27'b0, v.rt});
        check("rd_num",     {27'b0, bus.rd_num},   {27'b0, v.rd});
        check("sh_mount",   {27'b0, bus.sh_mount}, {27'b0, v.sh});
        check("func",       {26'b0, bus.func},     {26'b0, v.func});
        check("imm",        {16'b0, bus.imm},      {16'b0, v.imm});
        check("pc_value",   bus.pc_value, pc);
    endtask

    initial begin
        vec_t        vecs[6];
        vec_t        v_add;
        vec_t        v_lw;
        vec_t        v_sys;
        logic [31:0] exp_pc;

        n_cmp = 0;
        n_bad = 0;
        v_add = '{32'h014B4820, 6'h00, 5'd10, 5'd11, 5'd9, 5'd0, 6'h20, 16'h4820};
        v_lw  = '{32'h8D090004, 6'h23, 5'd8,  5'd9,  5'd0, 5'd0, 6'h04, 16'h0004};
        v_sys = '{32'h0000000C, 6'h00, 5'd0,  5'd0,  5'd0, 5'd0, 6'h0C, 16'h000C};
        vecs[0] = '{32'h00031080, 6'h00, 5'd0,  5'd3,  5'd2,  5'd2,  6'h00, 16'h1080};
        vecs[1] = '{32'hFFFFFFFF, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF};
        vecs[2] = '{32'h2129FFFF, 6'h08, 5'd9,  5'd9,  5'd31, 5'd31, 6'h3F, 16'hFFFF};
        vecs[3] = '{32'h0000000D, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h0D, 16'h000D};
        vecs[4] = '{32'h0400000C, 6'h01, 5'd0,  5'd0,  5'd0,  5'd0,  6'h0C, 16'h000C};
        vecs[5] = '{32'h00000000, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000};

        rst                = 1'b1;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (3) tick();

        // Reset state
        check("rst_req",    {31'b0, bus.imem_req},   32'd0);
        check("rst_valid",  {31'b0, bus.inst_valid}, 32'd0);
        check("rst_halted", {31'b0, bus.halted},     32'd0);
        check("rst_pc_val", bus.pc_value,            32'd0);
        check("rst_fields", {bus.opcode, bus.rs_num, bus.rt_num, bus.func}, 32'd0);
        check("rst_addr",   bus.imem_addr,           32'h0040_0000);

        // First fetch, then stall hold with a stray ack in ISSUE
        rst = 1'b0;
        do_fetch(v_add.word, 32'h0040_0000);
        check_fields(v_add, 32'h0040_0000);
        check("t1_req_low", {31'b0, bus.imem_req}, 32'd0);
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack   = (i == 2);
            bus.imem_rdata = 32'hFFFF_FFFF;
            tick();
            check("stall_req", {31'b0, bus.imem_req}, 32'd0);
            check("stall_rd",  {27'b0, bus.rd_num},   32'd9);
            check("stall_pc",  bus.pc_value,          32'h0040_0000);
        end
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        check_fields(v_add, 32'h0040_0000);
        bus.stall = 1'b0;
        tick();
        check("consume_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("consume_req",   {31'b0, bus.imem_req},   32'd1);
        check("consume_addr",  bus.imem_addr,           32'h0040_0004);

        // Slow memory: ack four cycles late, garbage on rdata meanwhile
        for (int i = 0; i < 4; i++) begin
            bus.imem_rdata = 32'hFFFF_FFFF;
            tick();
            check("slow_req",   {31'b0, bus.imem_req},   32'd1);
            check("slow_addr",  bus.imem_addr,           32'h0040_0004);
            check("slow_valid", {31'b0, bus.inst_valid}, 32'd0);
        end
        do_fetch(v_lw.word, 32'h0040_0004);
        check_fields(v_lw, 32'h0040_0004);

        // Table of decode vectors, back-to-back at minimum throughput
        exp_pc = 32'h0040_0008;
        foreach (vecs[i]) begin
            do_fetch(vecs[i].word, exp_pc);
            check_fields(vecs[i], exp_pc);
            exp_pc = exp_pc + 32'd4;
        end

        // Redirect: ignored while stalled, taken on consume with low bits cleared
        do_fetch(v_add.word, exp_pc);
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0103;
        tick();
        check("redir_stall_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("redir_stall_req",   {31'b0, bus.imem_req},   32'd0);
        bus.stall = 1'b0;
        tick();
        check("redir_addr", bus.imem_addr, 32'h0040_0100);
        bus.redirect_pc = 32'h0000_0040;
        tick();
        check("redir_fetch_ignore", bus.imem_addr, 32'h0040_0100);
        bus.redirect_valid = 1'b0;

        // PC wrap at the top of the address space
        do_fetch(32'h0, 32'h0040_0100);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        do_fetch(v_add.word, 32'hFFFF_FFFC);
        check_fields(v_add, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Syscall halts; redirect on that edge and later acks are ignored
        do_fetch(v_sys.word, 32'h0000_0000);
        check_fields(v_sys, 32'h0000_0000);
        check("sys_not_halted", {31'b0, bus.halted}, 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_1000;
        tick();
        bus.redirect_valid = 1'b0;
        check("sys_halted", {31'b0, bus.halted},     32'd1);
        check("sys_valid",  {31'b0, bus.inst_valid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack   = i[0];
            bus.imem_rdata = 32'h014B_4820;
            tick();
            check("halt_req", {31'b0, bus.imem_req}, 32'd0);
        end
        bus.imem_ack = 1'b0;
        check("halt_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("halt_hold",  {31'b0, bus.halted},     32'd1);

        // Reset out of HALT, then asynchronous reset during FETCH
        rst = 1'b1;
        tick();
        check("rst2_halted", {31'b0, bus.halted}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst2_req", {31'b0, bus.imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req",  {31'b0, bus.imem_req}, 32'd0);
        check("async_rst_addr", bus.imem_addr,         32'h0040_0000);
        tick();
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.imem_ack = 1'b0;
        check("late_ack_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("resume_req",     {31'b0, bus.imem_req},   32'd1);
        do_fetch(v_add.word, 32'h0040_0000);
        check_fields(v_add, 32'h0040_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
